// File: rtl/sfifo_thresh.sv
// Synchronous FWFT FIFO with run-time almost-full/almost-empty thresholds and overflow/underflow reporting.
// Define SFIFO_STICKY_ERR_EN to make the error flags sticky until i_clr_err or reset.
module sfifo_thresh #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [LGFLEN:0]   o_fill,
    input  logic [LGFLEN:0]   i_af_level,
    input  logic [LGFLEN:0]   i_ae_level,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    input  logic              i_clr_err,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam logic [LGFLEN:0] DEPTH_V = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN:0] PTR_ONE = {{LGFLEN{1'b0}}, 1'b1};

    logic [BW-1:0]   mem [DEPTH];
    logic [LGFLEN:0] wrAddr_q, wrAddr_d;
    logic [LGFLEN:0] rdAddr_q, rdAddr_d;
    logic [LGFLEN:0] fill;
    logic            isFull, isEmpty, wWr, wRd, ovfEv, unfEv;
    logic [BW-1:0]   memRd_q;
    logic [BW-1:0]   bypass_q, bypass_d;
    logic            bypassSel_q, bypassSel_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    always_comb begin
        fill     = wrAddr_q - rdAddr_q;
        isFull   = (fill == DEPTH_V);
        isEmpty  = (fill == '0);
        wWr      = i_wr && !isFull;
        wRd      = i_rd && !isEmpty;
        ovfEv    = i_wr && isFull && !wWr;
        unfEv    = i_rd && isEmpty;

        wrAddr_d = wrAddr_q;
        if (wWr) begin
            wrAddr_d = wrAddr_q + PTR_ONE;
        end
        rdAddr_d = rdAddr_q;
        if (wRd) begin
            rdAddr_d = rdAddr_q + PTR_ONE;
        end

        // The RAM read of an entry written this same edge would return stale data,
        // so a write landing on next cycle's head goes through the bypass register.
        bypassSel_d = wWr && (wrAddr_q == rdAddr_d);
        bypass_d    = bypassSel_d ? i_data : bypass_q;

`ifdef SFIFO_STICKY_ERR_EN
        ovf_d = ovfEv || (ovf_q && !i_clr_err);
        unf_d = unfEv || (unf_q && !i_clr_err);
`else
        ovf_d = ovfEv;
        unf_d = unfEv;
`endif
    end

`ifndef SFIFO_STICKY_ERR_EN
    logic unusedClrErr;
    assign unusedClrErr = i_clr_err;
`endif

    always_ff @(posedge i_clk) begin
        if (wWr) begin
            mem[wrAddr_q[LGFLEN-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            memRd_q <= '0;
        end else begin
            memRd_q <= mem[rdAddr_d[LGFLEN-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wrAddr_q    <= '0;
            rdAddr_q    <= '0;
            bypass_q    <= '0;
            bypassSel_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wrAddr_q    <= wrAddr_d;
            rdAddr_q    <= rdAddr_d;
            bypass_q    <= bypass_d;
            bypassSel_q <= bypassSel_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign o_data         = bypassSel_q ? bypass_q : memRd_q;
    assign o_fill         = fill;
    assign o_empty        = isEmpty;
    assign o_full         = isFull;
    assign o_almost_full  = (fill >= i_af_level);
    assign o_almost_empty = (fill <= i_ae_level);
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

endmodule

// File: tb/tb_sfifo_thresh.sv
// Testbench for sfifo_thresh: directed scenarios plus randomized traffic against a queue-based model.
module tb_sfifo_thresh;

    localparam int BW     = 8;
    localparam int LGFLEN = 4;
    localparam int DEPTH  = 1 << LGFLEN;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_rd;
    logic [BW-1:0]     o_data;
    logic              o_empty;
    logic              o_full;
    logic [LGFLEN:0]   o_fill;
    logic [LGFLEN:0]   i_af_level;
    logic [LGFLEN:0]   i_ae_level;
    logic              o_almost_full;
    logic              o_almost_empty;
    logic              i_clr_err;
    logic              o_overflow;
    logic              o_underflow;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] modelQ [$];
    bit            mOvf = 1'b0;
    bit            mUnf = 1'b0;
    bit            mJustReset = 1'b0;

    always #5 i_clk = ~i_clk;

    sfifo_thresh #(.BW(BW), .LGFLEN(LGFLEN)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_wr           (i_wr),
        .i_data         (i_data),
        .i_rd           (i_rd),
        .o_data         (o_data),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_fill         (o_fill),
        .i_af_level     (i_af_level),
        .i_ae_level     (i_ae_level),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .i_clr_err      (i_clr_err),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkThresholds();
        int n;
        n = modelQ.size();
        checkOutput("almost_full", 32'(o_almost_full), 32'(n >= int'(i_af_level)));
        checkOutput("almost_empty", 32'(o_almost_empty), 32'(n <= int'(i_ae_level)));
    endtask

    task automatic checkState();
        int n;
        n = modelQ.size();
        checkOutput("fill", 32'(o_fill), 32'(n));
        checkOutput("empty", 32'(o_empty), 32'(n == 0));
        checkOutput("full", 32'(o_full), 32'(n == DEPTH));
        checkOutput("overflow", 32'(o_overflow), 32'(mOvf));
        checkOutput("underflow", 32'(o_underflow), 32'(mUnf));
        checkThresholds();
        if (n > 0) begin
            checkOutput("data", 32'(o_data), 32'(modelQ[0]));
        end else if (mJustReset) begin
            checkOutput("data_reset", 32'(o_data), 32'h0);
        end
    endtask

    // Drives one cycle of requests, advances the reference model across the edge, then checks.
    task automatic applyStimulus(input bit wr, input logic [BW-1:0] data, input bit rd,
                                 input bit clr, input bit rstn);
        int n;
        bit accW, accR, ovfEv, unfEv;
        i_wr      = wr;
        i_data    = data;
        i_rd      = rd;
        i_clr_err = clr;
        i_reset_n = rstn;
        @(posedge i_clk);
        n = modelQ.size();
        if (!rstn) begin
            modelQ.delete();
            mOvf       = 1'b0;
            mUnf       = 1'b0;
            mJustReset = 1'b1;
        end else begin
            accW  = wr && (n < DEPTH);
            accR  = rd && (n > 0);
            ovfEv = wr && (n == DEPTH);
            unfEv = rd && (n == 0);
            if (accR) begin
                void'(modelQ.pop_front());
            end
            if (accW) begin
                modelQ.push_back(data);
            end
`ifdef SFIFO_STICKY_ERR_EN
            mOvf = ovfEv ? 1'b1 : (clr ? 1'b0 : mOvf);
            mUnf = unfEv ? 1'b1 : (clr ? 1'b0 : mUnf);
`else
            mOvf = ovfEv;
            mUnf = unfEv;
`endif
            mJustReset = 1'b0;
        end
        #1;
        checkState();
    endtask

    initial begin
        int phase;
        bit wr, rd;
        i_reset_n  = 1'b0;
        i_wr       = 1'b0;
        i_rd       = 1'b0;
        i_data     = '0;
        i_clr_err  = 1'b0;
        i_af_level = 5'd12;
        i_ae_level = 5'd3;

        applyStimulus(0, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'hEE, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 8'(i), 0, 0, 1);
        end
        applyStimulus(1, 8'h77, 1, 0, 1);
        applyStimulus(1, 8'h99, 0, 0, 1);
        applyStimulus(1, 8'h55, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 0, 0, 1);
        end
        applyStimulus(0, 8'h00, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 1);
        end
        applyStimulus(0, 8'h00, 1, 0, 1);
        applyStimulus(1, 8'hA5, 1, 0, 1);
        applyStimulus(1, 8'h3C, 1, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);

        i_af_level = 5'd0;
        i_ae_level = 5'd31;
        #1;
        checkThresholds();
        applyStimulus(1, 8'h11, 0, 0, 1);
        applyStimulus(1, 8'h22, 1, 0, 1);
        applyStimulus(1, 8'h33, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            phase = (cyc / 150) % 3;
            case (phase)
                0:       begin wr = ($urandom_range(0, 9) < 8); rd = ($urandom_range(0, 9) < 3); end
                1:       begin wr = ($urandom_range(0, 9) < 3); rd = ($urandom_range(0, 9) < 8); end
                default: begin wr = $urandom_range(0, 1) != 0; rd = $urandom_range(0, 1) != 0; end
            endcase
            applyStimulus(wr, 8'($urandom), rd, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) begin
                i_af_level = 5'($urandom_range(0, 31));
                i_ae_level = 5'($urandom_range(0, 31));
                #1;
                checkThresholds();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
